div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage, serving DIV/DIVU.
- Produces the EX-side stall request consumed by the pipeline controller.
- Obeys the controller's flush: an in-flight divide is annulled when an exception or ERET redirect flushes the pipeline.
- Result is {remainder, quotient}, written to HI/LO by the pipeline.

---
 rtl/div_unit_pkg.sv | 24 ++
 rtl/div_unit.sv | 159 +++++++++++++++
 tb/tb_div_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider and the pipeline controller.
package div_unit_pkg;

    // Divider FSM states.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Result-ready flag values.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Start-request values as driven by EX.
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Stall request values understood by the controller.
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. One quotient bit per cycle,
// signed operands handled as magnitudes with a sign fix-up at the end.
// Result layout is {remainder, quotient}.
//
// Handshake: EX raises start_i and holds it (with stable operands in the
// sampling cycle) until it sees ready_o. ready_o stays high, with result_o
// stable, for as long as start_i stays high; dropping start_i returns the
// unit to idle on the next edge. stall_req_o is high while a request is
// pending and no result is ready. annul_i aborts whatever is in progress.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_req_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*WIDTH:0]    dividend_q;   // {partial remainder, dividend/quotient bits, next bit}
    logic [WIDTH-1:0]    divisor_q;
    logic                quo_neg_q;
    logic                rem_neg_q;
    logic [2*WIDTH-1:0]  result_q;

    logic                start_ok;
    logic                divisor_zero;
    logic                op1_neg;
    logic                op2_neg;
    logic [WIDTH-1:0]    op1_mag;
    logic [WIDTH-1:0]    op2_mag;
    logic [WIDTH:0]      diff;
    logic [2*WIDTH:0]    step_next;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;

    // Operand conditioning and one restoring subtract-shift step.
    always_comb begin
        start_ok     = start_i && !annul_i;
        divisor_zero = (opdata2_i == '0);
        op1_neg      = signed_i && opdata1_i[WIDTH-1];
        op2_neg      = signed_i && opdata2_i[WIDTH-1];
        op1_mag      = op1_neg ? (-opdata1_i) : opdata1_i;
        op2_mag      = op2_neg ? (-opdata2_i) : opdata2_i;
        diff         = dividend_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
        if (diff[WIDTH]) begin
            step_next = {dividend_q[2*WIDTH-1:0], 1'b0};
        end else begin
            step_next = {diff[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
        end
        quo_fix = quo_neg_q ? (-dividend_q[WIDTH-1:0]) : dividend_q[WIDTH-1:0];
        rem_fix = rem_neg_q ? (-dividend_q[2*WIDTH:WIDTH+1]) : dividend_q[2*WIDTH:WIDTH+1];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; annul always returns to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (start_ok) begin
                    state_d = divisor_zero ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                state_d = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                if (annul_i || (start_i == DIV_STOP)) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // FSM outputs: ready while holding a result, stall while waiting for one.
    always_comb begin
        ready_o     = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
        stall_req_o = (start_i && (state_q != DIV_END)) ? STOP : NOSTOP;
        result_o    = result_q;
    end

    // Datapath: operand latch, iteration, sign fix-up and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    result_q <= '0;
                    cnt_q    <= '0;
                    if (start_ok && !divisor_zero) begin
                        dividend_q <= {{WIDTH{1'b0}}, op1_mag, 1'b0};
                        divisor_q  <= op2_mag;
                        quo_neg_q  <= op1_neg ^ op2_neg;
                        rem_neg_q  <= op1_neg;
                    end
                end
                DIV_BY_ZERO: begin
                    dividend_q <= '0;
                    result_q   <= '0;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        cnt_q    <= '0;
                        result_q <= '0;
                    end else if (cnt_q != CNT_LAST) begin
                        dividend_q <= step_next;
                        cnt_q      <= cnt_q + CNT_ONE;
                    end else begin
                        result_q <= {rem_fix, quo_fix};
                        cnt_q    <= '0;
                    end
                end
                DIV_END: begin
                    if (annul_i || (start_i == DIV_STOP)) begin
                        result_q <= '0;
                    end
                end
                default: result_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: per-cycle expected outputs from a latency
// rule plus an arithmetic reference model, checked on every falling edge.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  logic        chk_en;
  logic        exp_ready;
  logic        exp_stall;
  logic [63:0] exp_result;
  logic        exp_idle;

  int total;
  int bad;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: {remainder, quotient} from plain integer arithmetic
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check64("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
      check64("stall_req_o", {63'd0, stall_req_o}, {63'd0, exp_stall});
      check64("result_o", result_o, exp_result);
      if (exp_idle) begin
        check64("state_idle", {62'd0, dut.state_q}, {62'd0, DIV_FREE});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic r, input logic st, input logic [63:0] res, input logic idl);
    exp_ready  = r;
    exp_stall  = st;
    exp_result = res;
    exp_idle   = idl;
  endtask

  // one divide; hold = cycles start_i stays high past ready;
  // end_annul = annul in END instead of a plain start drop
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit end_annul);
    logic [63:0] r;
    int lat;
    r = model(s, a, b);
    lat = (b == 32'd0) ? 2 : 34;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    set_exp(1'b0, 1'b1, 64'd0, 1'b1);
    for (int c = 1; c <= lat + hold; c++) begin
      tick();
      opdata1_i = $urandom;
      opdata2_i = $urandom_range(0, 3);
      if (c >= lat) set_exp(1'b1, 1'b0, r, 1'b0);
      else          set_exp(1'b0, 1'b1, 64'd0, 1'b0);
    end
    tick();
    if (end_annul) annul_i = 1'b1;
    else           start_i = 1'b0;
    set_exp(1'b1, 1'b0, r, 1'b0);
    tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b1);
    tick();
  endtask

  // annul in ON at cycle 10
  task automatic do_annul(input logic [31:0] a, input logic [31:0] b);
    signed_i  = 1'b0;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    set_exp(1'b0, 1'b1, 64'd0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 10) annul_i = 1'b1;
      set_exp(1'b0, 1'b1, 64'd0, 1'b0);
    end
    tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b1);
    for (int c = 0; c < 30; c++) tick();
  endtask

  // start and annul together in idle: nothing begins
  task automatic do_idle_annul();
    signed_i  = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    set_exp(1'b0, 1'b1, 64'd0, 1'b1);
    for (int c = 0; c < 3; c++) tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b1);
    tick();
  endtask

  // synchronous reset while ON
  task automatic do_mid_reset();
    signed_i  = 1'b1;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    set_exp(1'b0, 1'b1, 64'd0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      set_exp(1'b0, 1'b1, 64'd0, 1'b0);
    end
    rst     = 1'b1;
    start_i = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b0);
    tick();
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b1);
    for (int c = 0; c < 40; c++) tick();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    chk_en    = 1'b0;
    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    annul_i   = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b1);

    // pin the model with hand-computed values
    check64("model_100_7",     model(1'b0, 32'd100, 32'd7),              64'h00000002_0000000E);
    check64("model_m7_2",      model(1'b1, 32'hFFFF_FFF9, 32'd2),        64'hFFFFFFFF_FFFFFFFD);
    check64("model_7_m2",      model(1'b1, 32'd7, 32'hFFFF_FFFE),        64'h00000001_FFFFFFFD);
    check64("model_intmin_m1", model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h00000000_80000000);
    check64("model_15_4",      model(1'b0, 32'd15, 32'd4),               64'h00000003_00000003);
    check64("model_div0",      model(1'b1, 32'd9, 32'd0),                64'd0);

    // reset state
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    do_div(1'b0, 32'd123, 32'd0, 0, 1'b0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, 1, 1'b0);
    do_annul(32'd999, 32'd10);
    do_div(1'b0, 32'd15, 32'd4, 0, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd3, 5, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1'b0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 1'b0);
    do_div(1'b0, 32'd5, 32'd10, 0, 1'b0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_div(1'b1, 32'd77, 32'd8, 2, 1'b1);
    do_idle_annul();
    do_mid_reset();
    do_div(1'b0, 32'd42, 32'd6, 0, 1'b0);

    chk_en = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
